// File: rtl/pager_multi.sv
// Multi-channel pager alarm detector: sticky per-channel alarm after RUN_LEN sampled zeros, shared beeper z.
// Latency: alarm rises on the edge sampling the RUN_LEN-th zero, z first rises BEEP_DIV clks later; no backpressure.
module pager_multi #(
  parameter int CHANNELS = 4,
  parameter int RUN_LEN  = 3,
  parameter int BEEP_DIV = 8,
  localparam int CNT_W = $clog2(RUN_LEN + 1),
  localparam int ID_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int DIV_W = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] x,
  input  logic [CHANNELS-1:0] ack,
  output logic [CHANNELS-1:0] alarm,
  output logic                alarm_any,
  output logic [ID_W-1:0]     alarm_id,
  output logic                z
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_ALARM = 2'd2;
  localparam logic [1:0] ST_REARM = 2'd3;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]       st, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             alarm_q;

    always_comb begin
      st_nxt  = st;
      cnt_nxt = cnt;
      case (st)
        ST_IDLE: begin
          if (sample_en && !x[i]) begin
            if (RUN_LEN == 1) begin
              st_nxt = ST_ALARM;
            end else begin
              st_nxt  = ST_COUNT;
              cnt_nxt = CNT_W'(1);
            end
          end
        end
        ST_COUNT: begin
          if (sample_en) begin
            if (!x[i]) begin
              // Terminal zero of the run: counter resets so it never reaches RUN_LEN.
              if (cnt == CNT_W'(RUN_LEN - 1)) begin
                st_nxt  = ST_ALARM;
                cnt_nxt = '0;
              end else begin
                cnt_nxt = cnt + CNT_W'(1);
              end
            end else begin
              st_nxt  = ST_IDLE;
              cnt_nxt = '0;
            end
          end
        end
        ST_ALARM: begin
          if (ack[i]) st_nxt = ST_REARM;
        end
        default: begin
          if (sample_en && x[i]) st_nxt = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st      <= ST_IDLE;
        cnt     <= '0;
        alarm_q <= 1'b0;
      end else begin
        st      <= st_nxt;
        cnt     <= cnt_nxt;
        alarm_q <= (st_nxt == ST_ALARM);
      end
    end

    assign alarm[i] = alarm_q;
  end

  assign alarm_any = |alarm;

  always_comb begin
    alarm_id = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (alarm[i]) alarm_id = ID_W'(i);
    end
  end

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      z   <= 1'b0;
    end else if (!alarm_any) begin
      div <= '0;
      z   <= 1'b0;
    end else if (div == DIV_W'(BEEP_DIV - 1)) begin
      div <= '0;
      z   <= ~z;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_pager_multi.sv
// Bench for pager_multi: directed scenarios plus randomized traffic against a behavioural run-length model.
module tb_pager_multi;
  localparam int CH = 4;
  localparam int RL = 3;
  localparam int BD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_en;
  logic [CH-1:0] x, ack;
  logic [CH-1:0] alarm;
  logic          alarm_any;
  logic [1:0]    alarm_id;
  logic          z;

  logic          se1;
  logic [1:0]    x1, ack1, alarm1;
  logic          any1, id1, z1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pager_multi #(.CHANNELS(CH), .RUN_LEN(RL), .BEEP_DIV(BD)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .x(x), .ack(ack),
    .alarm(alarm), .alarm_any(alarm_any), .alarm_id(alarm_id), .z(z)
  );

  pager_multi #(.CHANNELS(2), .RUN_LEN(1), .BEEP_DIV(2)) dut1 (
    .clk(clk), .rst(rst), .sample_en(se1), .x(x1), .ack(ack1),
    .alarm(alarm1), .alarm_any(any1), .alarm_id(id1), .z(z1)
  );

  // Reference model: run length of zeros seen, whether a 1 is still owed after an ack,
  // and how many consecutive edges the beeper has been enabled.
  int run [CH];
  bit m_alarm [CH];
  bit owe_one [CH];
  int hi_cnt;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      run[i] = 0; m_alarm[i] = 0; owe_one[i] = 0;
    end
    hi_cnt = 0;
  endtask

  task automatic model_edge();
    bit any_pre;
    any_pre = 0;
    for (int i = 0; i < CH; i++) any_pre |= m_alarm[i];
    for (int i = 0; i < CH; i++) begin
      if (m_alarm[i]) begin
        if (ack[i]) begin m_alarm[i] = 0; owe_one[i] = 1; end
      end else if (owe_one[i]) begin
        if (sample_en && x[i]) owe_one[i] = 0;
      end else if (sample_en) begin
        if (!x[i]) begin
          run[i]++;
          if (run[i] == RL) begin m_alarm[i] = 1; run[i] = 0; end
        end else begin
          run[i] = 0;
        end
      end
    end
    hi_cnt = any_pre ? hi_cnt + 1 : 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    logic [CH-1:0] ea;
    logic [1:0]    eid;
    ea = '0;
    eid = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      ea[i] = m_alarm[i];
      if (m_alarm[i]) eid = 2'(i);
    end
    chk("alarm", 32'(alarm), 32'(ea));
    chk("alarm_any", 32'(alarm_any), 32'(|ea));
    chk("alarm_id", 32'(alarm_id), 32'(eid));
    chk("z", 32'(z), 32'((hi_cnt / BD) % 2));
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
    end
  endtask

  task automatic clear_all();
    x = '1; ack = '1; sample_en = 1'b1;
    step(2);
    ack = '0;
    step(1);
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; x = '1; ack = '0;
    se1 = 1'b0; x1 = 2'b11; ack1 = 2'b00;
    model_reset();
    #3;
    chk("rst_alarm", 32'(alarm), 32'h0);
    chk("rst_z", 32'(z), 32'h0);
    chk("rst_id", 32'(alarm_id), 32'h0);
    chk("rst_any", 32'(alarm_any), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(2);

    // RUN_LEN=1 instance: single zero alarms, held ack clears on the following edge.
    se1 = 1'b1; x1 = 2'b11;
    step(1);
    x1 = 2'b10;
    step(1);
    chk("rl1_alarm", 32'(alarm1), 32'h1);
    chk("rl1_id", 32'(id1), 32'h0);
    ack1 = 2'b01;
    step(1);
    chk("rl1_ack", 32'(alarm1), 32'h0);
    step(2);
    chk("rl1_rearm", 32'(alarm1), 32'h0);
    ack1 = 2'b00; x1 = 2'b11; se1 = 1'b0;

    // Channel 0: three zero strobes, with an idle strobe gap inside the run.
    sample_en = 1'b1; x = 4'b1110;
    step(2);
    sample_en = 1'b0;
    step(2);
    chk("ch0_hold", 32'(alarm), 32'h0);
    sample_en = 1'b1;
    step(1);
    chk("ch0_alarm", 32'(alarm), 32'h1);
    chk("ch0_id", 32'(alarm_id), 32'h0);
    x = 4'b1111;
    step(7);
    chk("z_before", 32'(z), 32'h0);
    step(1);
    chk("z_rise", 32'(z), 32'h1);
    step(8);
    chk("z_fall", 32'(z), 32'h0);
    clear_all();

    // Channel 1: broken run does not alarm, contiguous run does.
    foreach (run[i]) if (i < 0) ;
    x = 4'b1101; step(2);
    x = 4'b1111; step(1);
    x = 4'b1101; step(2);
    chk("ch1_noalarm", 32'(alarm), 32'h0);
    step(1);
    chk("ch1_alarm", 32'(alarm), 32'h2);
    clear_all();

    // Channel 2: ack while zeros continue, no re-alarm until a 1 is seen.
    x = 4'b1011; step(3);
    chk("ch2_alarm", 32'(alarm), 32'h4);
    step(2);
    ack = 4'b0100; step(1);
    chk("ch2_ack", 32'(alarm), 32'h0);
    ack = 4'b0000; step(4);
    chk("ch2_zeros_ignored", 32'(alarm), 32'h0);
    x = 4'b1111; step(1);
    x = 4'b1011; step(3);
    chk("ch2_realarm", 32'(alarm), 32'h4);
    clear_all();

    // Channels 1 and 3 together, then ack the lower one.
    x = 4'b0101; step(3);
    chk("ch13_alarm", 32'(alarm), 32'ha);
    chk("ch13_id", 32'(alarm_id), 32'h1);
    x = 4'b1111; ack = 4'b0010; step(1);
    ack = 4'b0000;
    chk("ch3_id", 32'(alarm_id), 32'h3);
    step(12);

    // Async reset with channel 0 mid-count and beeper running.
    x = 4'b1110; step(2);
    rst = 1'b1;
    #2;
    chk("arst_alarm", 32'(alarm), 32'h0);
    chk("arst_z", 32'(z), 32'h0);
    model_reset();
    #1;
    rst = 1'b0;
    step(2);
    chk("arst_restart", 32'(alarm), 32'h0);
    clear_all();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      sample_en = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < CH; i++) begin
        x[i]   = ($urandom_range(0, 9) >= 6);
        ack[i] = ($urandom_range(0, 9) == 0);
      end
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
